instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage of the 9-bit core. It owns the program counter and drives the address into the instruction ROM, which returns data combinationally. Each cycle it registers the returned word into a one-deep fetch register for decode. It handles start, stall, taken-branch flush and halt detection, and reports program completion with `done`.

## Interface
- `A`, 10: PC / ROM address width.
- `W`, 9: instruction width.
- `HALT_WORD`, 9'h1FF: instruction encoding that ends the program.
- `START_PC`, 0: PC value loaded on `start`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin, or restart, execution from `START_PC`.
- `stall`  in  1: downstream hold; freezes the PC and the fetch register.
- `branch_taken`  in  1: the instruction currently in `instr_q` resolved as a taken branch.
- `branch_target`  in  A: absolute target PC, valid with `branch_taken`.
- `instr_in`  in  W: ROM data for `instr_address`.
- `instr_address`  out  A: equals the PC register; drives the ROM.
- `instr_q`  out  W: registered fetched instruction.
- `instr_valid`  out  1: `instr_q` holds a live instruction.
- `pc_q`  out  A: address of the instruction in `instr_q`.
- `done`  out  1: the program has halted.
- `cycle_count`  out  16: active-cycle counter (see Configuration).

## Operation
- States: `IDLE`, `RUN`, `HALT`.
- Reset (`rst_n`=0, async) forces:
  - state `IDLE`, PC 0, `instr_q` 0, `pc_q` 0;
  - `instr_valid` 0, `done` 0, `cycle_count` 0.
- `IDLE`: PC held. When `start`=1: PC ← `START_PC`, state → `RUN`; `instr_valid` stays 0.
- `RUN` with `stall`=1: PC, `instr_q`, `pc_q`, `instr_valid` and state all hold. `branch_taken` is ignored; downstream must hold it until the stall drops.
- `RUN` with `stall`=0 and `branch_taken`=1 (flush):
  - PC ← `branch_target`;
  - `instr_valid` ← 0;
  - `instr_in` is discarded and never checked against `HALT_WORD`.
- `RUN` with `stall`=0 and `branch_taken`=0 (advance):
  - `instr_q` ← `instr_in`, `pc_q` ← PC, `instr_valid` ← 1;
  - PC ← PC+1, modulo 2^A: PC 2^A−1 wraps to 0.
  - If `instr_in` == `HALT_WORD`, the word is captured as above and state → `HALT`.
- `HALT`:
  - `done`=1 and PC holds.
  - `instr_valid` is 1 for the first `HALT` cycle (halt word visible), then 0.
  - `branch_taken` and `stall` are ignored.
  - `start`=1: PC ← `START_PC`, `done` ← 0, `instr_valid` ← 0, state → `RUN`.
- `start` while in `RUN` is ignored.
- Simultaneous `branch_taken` and a `HALT_WORD` on `instr_in`: the flush wins and the state stays `RUN`.

## Timing
- `instr_address` is a registered output with no combinational input path. The ROM read fits in the same cycle.
- Fetch-to-`instr_q` latency: 1 cycle. Sustained throughput: 1 instruction/cycle with no stalls.
- Taken-branch penalty: 1 bubble. The target instruction appears in `instr_q` 2 edges after the edge that samples `branch_taken`.
- `start` to first `instr_valid`: 2 edges.
- `done` rises on the edge that captures `HALT_WORD`, together with that word's `instr_valid`.
- Reset asserted mid-run takes effect immediately, without waiting for a clock edge. Deassertion is synchronized externally.

## Configuration
- Macro `FETCH_CYCLE_COUNT_EN`.
- Defined:
  - `cycle_count` increments by 1 on every clock edge where state is `RUN`, including stall cycles; it saturates at 16'hFFFF.
  - It holds in `HALT` and clears on reset and on `start`.
- Undefined: `cycle_count` is tied to 0 and no counter flops are inferred.

## Test plan
- Straight line: ROM[0..3] = 9'h001, 9'h002, 9'h003, 9'h1FF; pulse `start`. Required:
  - `instr_q` shows 001, 002, 003, 1FF on consecutive cycles, with `pc_q` 0..3;
  - `done`=1 in the same cycle as 1FF; `instr_valid` is 0 one cycle later;
  - with the macro, `cycle_count`=4.
- Branch flush: `branch_taken`=1 with target 10'h020 while `instr_q` is at `pc_q`=5. Required: one cycle with `instr_valid`=0, then `pc_q`=0x020; PC 6 is never presented.
- Stall: hold `stall`=1 for 3 cycles at PC 7. Required: `instr_address`, `instr_q` and `pc_q` are unchanged for 3 cycles; execution resumes with PC 7 captured.
- Branch over halt: `instr_in`=1FF while `branch_taken`=1 with target 0x010. Required: `done` stays 0 and `pc_q` next shows 0x010.
- Wrap: `START_PC`=10'h3FE with ROM[0x3FE], ROM[0x3FF] and ROM[0] all non-halt. Required: `pc_q` sequence 3FE, 3FF, 000.
- Reset mid-run: drop `rst_n` between edges. Required: `instr_valid`=0, `done`=0, PC 0 before the next edge; a restart via `start` then fetches from `START_PC`.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage of the 9-bit core: owns the PC, registers ROM data into a one-deep fetch register.
// Optional active-cycle counter is enabled by defining FETCH_CYCLE_COUNT_EN.
module instr_fetch #(
  parameter int unsigned  A         = 10,
  parameter int unsigned  W         = 9,
  parameter logic [W-1:0] HALT_WORD = 9'h1FF,
  parameter logic [A-1:0] START_PC  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [A-1:0] branch_target,
  input  logic [W-1:0] instr_in,
  output logic [A-1:0] instr_address,
  output logic [W-1:0] instr_q,
  output logic         instr_valid,
  output logic [A-1:0] pc_q,
  output logic         done,
  output logic [15:0]  cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [A-1:0] pc_d;
  logic [W-1:0] instr_d;
  logic         valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = START_PC;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (branch_taken) begin
            // Flush: the word at the old PC is dropped, so it can never halt us.
            addr_d  = branch_target;
            valid_d = 1'b0;
          end else begin
            instr_d = instr_in;
            pc_d    = addr_q;
            valid_d = 1'b1;
            addr_d  = addr_q + A'(1);
            if (instr_in == HALT_WORD) begin
              state_d = S_HALT;
            end
          end
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (start) begin
          addr_d  = START_PC;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign instr_address = addr_q;
  assign instr_valid   = valid_q;
  assign done          = (state_q == S_HALT);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts RUN cycles (stalls included), saturating; only a real start clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (start && (state_q == S_IDLE || state_q == S_HALT)) begin
      cnt_d = '0;
    end else if (state_q == S_RUN && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reset, straight-line run to halt, stall, flushes,
// branch over halt, start ignored in RUN, mid-run reset and PC wrap (second instance).
module tb_instr_fetch;

  localparam int A = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n, start, stall, branch_taken;
  logic [A-1:0] branch_target;
  logic [W-1:0] instr_in;
  logic [A-1:0] instr_address, pc_q;
  logic [W-1:0] instr_q;
  logic         instr_valid, done;
  logic [15:0]  cycle_count;

  logic         rst2_n, start2;
  logic [W-1:0] instr_in2;
  logic [A-1:0] instr_address2, pc_q2;
  logic [W-1:0] instr_q2;
  logic         instr_valid2, done2;
  logic [15:0]  cycle_count2;

  logic [W-1:0] rom [0:1023];

  always #5 clk = ~clk;

  always_comb instr_in  = rom[instr_address];
  always_comb instr_in2 = rom[instr_address2];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_in(instr_in), .instr_address(instr_address), .instr_q(instr_q),
    .instr_valid(instr_valid), .pc_q(pc_q), .done(done), .cycle_count(cycle_count)
  );

  instr_fetch #(.START_PC(10'h3FE)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .start(start2), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(10'h000),
    .instr_in(instr_in2), .instr_address(instr_address2), .instr_q(instr_q2),
    .instr_valid(instr_valid2), .pc_q(pc_q2), .done(done2), .cycle_count(cycle_count2)
  );

  typedef struct {
    logic         st;
    logic         sl;
    logic         br;
    logic [A-1:0] tgt;
    logic [A-1:0] e_addr;
    logic         e_valid;
    logic [A-1:0] e_pc;
    logic         e_done;
  } vec_t;

  typedef struct {
    logic [A-1:0] pc;
    logic [W-1:0] instr;
    logic         dn;
  } sb_t;

  vec_t vecs [20];
  sb_t  sbq [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic sb_en    = 1'b0;
  logic sb_sel   = 1'b0;

  // Background ROM contents: never the halt word since bit 8 is always clear.
  function automatic logic [W-1:0] romv(input int i);
    logic [W-1:0] r;
    r = 9'((i * 7 + 3) & 255);
    return r;
  endfunction

  function automatic vec_t mk(input logic st, input logic sl, input logic br,
                              input logic [A-1:0] tgt, input logic [A-1:0] e_addr,
                              input logic e_valid, input logic [A-1:0] e_pc,
                              input logic e_done);
    vec_t v;
    v.st = st; v.sl = sl; v.br = br; v.tgt = tgt;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_done = e_done;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    start         = v.st;
    stall         = v.sl;
    branch_taken  = v.br;
    branch_target = v.tgt;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every newly valid fetch word must match the next queued expectation.
  always @(negedge clk) begin
    if (sb_en) begin
      logic         v, dn;
      logic [A-1:0] p;
      logic [W-1:0] q;
      sb_t          e;
      v  = sb_sel ? instr_valid2 : instr_valid;
      p  = sb_sel ? pc_q2 : pc_q;
      q  = sb_sel ? instr_q2 : instr_q;
      dn = sb_sel ? done2 : done;
      if (v) begin
        checkOutput("sb_pending", 16'(sbq.size() != 0), 16'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checkOutput("sb_pc", 16'(p), 16'(e.pc));
          checkOutput("sb_instr", 16'(q), 16'(e.instr));
          checkOutput("sb_done", 16'(dn), 16'(e.dn));
        end
      end
    end
  end

  initial begin
    logic [15:0] exp_cnt;
    rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 1024; i++) rom[i] = romv(i);

    #12;
    checkOutput("rst_addr", 16'(instr_address), 16'h0);
    checkOutput("rst_instr", 16'(instr_q), 16'h0);
    checkOutput("rst_valid", 16'(instr_valid), 16'h0);
    checkOutput("rst_pc", 16'(pc_q), 16'h0);
    checkOutput("rst_done", 16'(done), 16'h0);
    checkOutput("rst_cnt", cycle_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line program ending in the halt word.
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h1FF;
    sbq.push_back('{pc: 10'h0, instr: 9'h001, dn: 1'b0});
    sbq.push_back('{pc: 10'h1, instr: 9'h002, dn: 1'b0});
    sbq.push_back('{pc: 10'h2, instr: 9'h003, dn: 1'b0});
    sbq.push_back('{pc: 10'h3, instr: 9'h1FF, dn: 1'b1});
    sb_sel = 1'b0;
    sb_en  = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_addr", 16'(instr_address), 16'h0);
    checkOutput("start_valid", 16'(instr_valid), 16'h0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("halt_done", 16'(done), 16'h1);
    checkOutput("halt_valid", 16'(instr_valid), 16'h1);
    checkOutput("halt_instr", 16'(instr_q), 16'h1FF);
    @(posedge clk); #1;
    sb_en = 1'b0;
    checkOutput("halt2_valid", 16'(instr_valid), 16'h0);
    checkOutput("halt2_done", 16'(done), 16'h1);
    checkOutput("halt2_addr", 16'(instr_address), 16'h4);
`ifdef FETCH_CYCLE_COUNT_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif
    checkOutput("halt_cnt", cycle_count, exp_cnt);
    checkOutput("sb_drained", 16'(sbq.size()), 16'h0);

    // Restart from HALT, then the table covers stall, flushes, branch over halt.
    for (int i = 0; i < 4; i++) rom[i] = romv(i);
    rom[10'h021] = 9'h1FF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_addr", 16'(instr_address), 16'h0);
    checkOutput("restart_valid", 16'(instr_valid), 16'h0);
    checkOutput("restart_done", 16'(done), 16'h0);

    vecs[0]  = mk(0, 0, 0, 10'h000, 10'h001, 1, 10'h000, 0);
    vecs[1]  = mk(0, 0, 0, 10'h000, 10'h002, 1, 10'h001, 0);
    vecs[2]  = mk(0, 0, 0, 10'h000, 10'h003, 1, 10'h002, 0);
    vecs[3]  = mk(0, 0, 0, 10'h000, 10'h004, 1, 10'h003, 0);
    vecs[4]  = mk(0, 0, 0, 10'h000, 10'h005, 1, 10'h004, 0);
    vecs[5]  = mk(0, 0, 0, 10'h000, 10'h006, 1, 10'h005, 0);
    vecs[6]  = mk(0, 0, 0, 10'h000, 10'h007, 1, 10'h006, 0);
    vecs[7]  = mk(0, 1, 0, 10'h000, 10'h007, 1, 10'h006, 0);
    vecs[8]  = mk(0, 1, 0, 10'h000, 10'h007, 1, 10'h006, 0);
    vecs[9]  = mk(0, 1, 0, 10'h000, 10'h007, 1, 10'h006, 0);
    vecs[10] = mk(0, 0, 0, 10'h000, 10'h008, 1, 10'h007, 0);
    vecs[11] = mk(0, 0, 1, 10'h005, 10'h005, 0, 10'h000, 0);
    vecs[12] = mk(0, 0, 0, 10'h000, 10'h006, 1, 10'h005, 0);
    vecs[13] = mk(0, 0, 1, 10'h020, 10'h020, 0, 10'h000, 0);
    vecs[14] = mk(0, 0, 0, 10'h000, 10'h021, 1, 10'h020, 0);
    vecs[15] = mk(0, 0, 1, 10'h010, 10'h010, 0, 10'h000, 0);
    vecs[16] = mk(0, 0, 0, 10'h000, 10'h011, 1, 10'h010, 0);
    vecs[17] = mk(0, 1, 1, 10'h030, 10'h011, 1, 10'h010, 0);
    vecs[18] = mk(0, 0, 0, 10'h000, 10'h012, 1, 10'h011, 0);
    vecs[19] = mk(1, 0, 0, 10'h000, 10'h013, 1, 10'h012, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_addr", i), 16'(instr_address), 16'(vecs[i].e_addr));
      checkOutput($sformatf("v%0d_valid", i), 16'(instr_valid), 16'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d_done", i), 16'(done), 16'(vecs[i].e_done));
      if (vecs[i].e_valid) begin
        checkOutput($sformatf("v%0d_pc", i), 16'(pc_q), 16'(vecs[i].e_pc));
        checkOutput($sformatf("v%0d_instr", i), 16'(instr_q), 16'(romv(int'(vecs[i].e_pc))));
      end
    end
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
`ifdef FETCH_CYCLE_COUNT_EN
    exp_cnt = 16'd20;
`else
    exp_cnt = 16'd0;
`endif
    checkOutput("run_cnt", cycle_count, exp_cnt);

    // Asynchronous reset between edges must act before the next edge.
    #3;
    rst_n = 1'b0;
    #2;
    checkOutput("async_valid", 16'(instr_valid), 16'h0);
    checkOutput("async_done", 16'(done), 16'h0);
    checkOutput("async_addr", 16'(instr_address), 16'h0);
    checkOutput("async_pc", 16'(pc_q), 16'h0);
    checkOutput("async_cnt", cycle_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("rerun_valid", 16'(instr_valid), 16'h1);
    checkOutput("rerun_pc", 16'(pc_q), 16'h0);
    checkOutput("rerun_instr", 16'(instr_q), 16'(romv(0)));
    checkOutput("rerun_addr", 16'(instr_address), 16'h1);

    // PC wrap on the instance whose start address is 0x3FE.
    @(negedge clk);
    rst2_n = 1'b1;
    sbq.push_back('{pc: 10'h3FE, instr: romv(10'h3FE), dn: 1'b0});
    sbq.push_back('{pc: 10'h3FF, instr: romv(10'h3FF), dn: 1'b0});
    sbq.push_back('{pc: 10'h000, instr: romv(0), dn: 1'b0});
    sb_sel = 1'b1;
    sb_en  = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    checkOutput("wrap_start_addr", 16'(instr_address2), 16'h3FE);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("wrap_addr", 16'(instr_address2), 16'h001);
    @(negedge clk); #1;
    sb_en = 1'b0;
    checkOutput("wrap_drained", 16'(sbq.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
